// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional stall/flush performance counters are enabled by defining IF_ID_PERF_EN.
module if_id_skid_reg #(
  parameter int unsigned         INSTRUCTION = 32,
  parameter int unsigned         ADDRESS     = 32,
  parameter logic [INSTRUCTION-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTRUCTION-1:0] in_instruction,
  input  logic [ADDRESS-1:0]     in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTRUCTION-1:0] out_instruction,
  output logic [ADDRESS-1:0]     out_pc,
  output logic [ADDRESS-1:0]     out_pc_plus4,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
);

  logic                   main_v_q, main_v_d;
  logic [INSTRUCTION-1:0] main_instr_q, main_instr_d;
  logic [ADDRESS-1:0]     main_pc_q, main_pc_d;
  logic [ADDRESS-1:0]     main_pc4_q, main_pc4_d;
  logic                   skid_v_q, skid_v_d;
  logic [INSTRUCTION-1:0] skid_instr_q, skid_instr_d;
  logic [ADDRESS-1:0]     skid_pc_q, skid_pc_d;
  logic                   in_ready_q, in_ready_d;
  logic                   accept;
  logic                   pop;

  assign accept = in_valid && in_ready_q;
  assign pop    = main_v_q && out_ready;

  // Main always holds NOP_INSTR while empty, so out_instruction needs no output mux.
  always_comb begin
    main_v_d     = main_v_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_v_d     = 1'b0;
      skid_v_d     = 1'b0;
      main_instr_d = NOP_INSTR;
    end else if (!main_v_q || pop) begin
      if (skid_v_q) begin
        main_v_d     = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_v_d     = accept;
        if (accept) begin
          skid_instr_d = in_instruction;
          skid_pc_d    = in_pc;
        end
      end else if (accept) begin
        main_v_d     = 1'b1;
        main_instr_d = in_instruction;
        main_pc_d    = in_pc;
      end else begin
        main_v_d     = 1'b0;
        main_instr_d = NOP_INSTR;
      end
    end else if (accept) begin
      skid_v_d     = 1'b1;
      skid_instr_d = in_instruction;
      skid_pc_d    = in_pc;
    end
    main_pc4_d = main_pc_d + ADDRESS'(4);
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v_q     <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      main_pc4_q   <= ADDRESS'(4);
      skid_v_q     <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_v_q     <= main_v_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_pc4_q   <= main_pc4_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = main_v_q;
  assign out_instruction = main_instr_q;
  assign out_pc          = main_pc_q;
  assign out_pc_plus4    = main_pc4_q;

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v_q && !out_ready && stall_cnt_q != 32'hFFFFFFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (main_v_q || skid_v_q) && flush_cnt_q != 32'hFFFFFFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
